// File: rtl/opamp_pole_stream.sv
// opamp_pole_stream -- sampled-data op-amp macromodel.
//
// Takes a valid/ready stream of differential sample pairs (in_p, in_n),
// applies a power-of-two forward gain and a single dominant pole
// (alpha = 2^-SHIFT), and emits a saturated single-ended stream on y.
// Two register stages: stage 1 captures the scaled difference, stage 2
// runs the leaky integrator and the output saturator.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   clr             synchronous clear of filter state, pipeline and FSM
//   s_valid/s_ready input handshake; in_p, in_n signed DW-bit samples
//   m_valid/m_ready output handshake; y signed DW-bit filtered output
//   settled         SETTLE_CNT outputs produced since reset/clr
//
// Build option OPA_SAT_STATUS_EN adds:
//   sat             y currently holds a clamped value
//   sat_sticky      a clamp has occurred since reset/clr
module opamp_pole_stream #(
  parameter int DW         = 16,
  parameter int GAIN_LOG2  = 4,
  parameter int SHIFT      = 4,
  parameter int SETTLE_CNT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] in_p,
  input  logic signed [DW-1:0] in_n,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] y,
  output logic                 settled
`ifdef OPA_SAT_STATUS_EN
  ,
  output logic                 sat,
  output logic                 sat_sticky
`endif
);

  localparam int GW = DW + 1 + GAIN_LOG2;          // scaled difference width
  localparam int AW = DW + GAIN_LOG2 + SHIFT + 2;  // accumulator width
  localparam int CW = $clog2(SETTLE_CNT + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETTLING = 2'd1;
  localparam logic [1:0] ST_TRACKING = 2'd2;

  localparam logic signed [AW-1:0] Y_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic                 en;
  logic                 accept;
  logic signed [DW:0]   diff;
  logic signed [GW-1:0] g_d, g_q;
  logic                 v1_d, v1_q;
  logic signed [AW-1:0] acc_d, acc_q;
  logic signed [AW-1:0] g_ext, acc_shr, acc_next, acc_out;
  logic                 clamp_hi, clamp_lo;
  logic signed [DW-1:0] y_sat, y_d, y_q;
  logic                 m_valid_d, m_valid_q;
  logic [1:0]           state_d, state_q;
  logic [CW-1:0]        cnt_d, cnt_q;
  logic                 settled_d, settled_q;
`ifdef OPA_SAT_STATUS_EN
  logic                 sat_d, sat_q;
  logic                 sticky_d, sticky_q;
`endif

  // Datapath: handshake, difference, leaky integrator, saturator.
  always_comb begin
    en      = !m_valid_q || m_ready;
    s_ready = en && !clr;
    accept  = s_valid && s_ready;
    // DW+1 bits hold any difference of two DW-bit signed values.
    diff    = {in_p[DW-1], in_p} - {in_n[DW-1], in_n};
    // Signed operands kept in separate signed variables so the shifts stay
    // arithmetic (floor toward -inf) instead of collapsing to logical.
    g_ext    = AW'(g_q);
    acc_shr  = acc_q >>> SHIFT;
    acc_next = acc_q + g_ext - acc_shr;
    acc_out  = acc_next >>> SHIFT;
    clamp_hi = acc_out > Y_MAX;
    clamp_lo = acc_out < Y_MIN;
    if (clamp_hi)      y_sat = Y_MAX[DW-1:0];
    else if (clamp_lo) y_sat = Y_MIN[DW-1:0];
    else               y_sat = acc_out[DW-1:0];
  end

  // Next-state logic for both stages and the settle FSM.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned -- that is what keeps always_comb from inferring latches.
    g_d       = g_q;
    v1_d      = v1_q;
    acc_d     = acc_q;
    y_d       = y_q;
    m_valid_d = m_valid_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    settled_d = settled_q;
`ifdef OPA_SAT_STATUS_EN
    sat_d     = sat_q;
    sticky_d  = sticky_q;
`endif
    if (clr) begin
      // clr wins over a stall: any pending output is dropped.
      g_d       = '0;
      v1_d      = 1'b0;
      acc_d     = '0;
      y_d       = '0;
      m_valid_d = 1'b0;
      state_d   = ST_IDLE;
      cnt_d     = '0;
      settled_d = 1'b0;
`ifdef OPA_SAT_STATUS_EN
      sat_d     = 1'b0;
      sticky_d  = 1'b0;
`endif
    end else if (en) begin
      v1_d = accept;
      if (accept) g_d = GW'(diff) <<< GAIN_LOG2;
      if (v1_q) begin
        acc_d     = acc_next;
        y_d       = y_sat;
        m_valid_d = 1'b1;
`ifdef OPA_SAT_STATUS_EN
        sat_d     = clamp_hi || clamp_lo;
        sticky_d  = sticky_q || clamp_hi || clamp_lo;
`endif
        // Counter holds the number of updates so far; the update that
        // brings it to SETTLE_CNT raises settled with that same output.
        if (state_q != ST_TRACKING) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(SETTLE_CNT - 1)) begin
            state_d   = ST_TRACKING;
            settled_d = 1'b1;
          end else begin
            state_d = ST_SETTLING;
          end
        end
      end else begin
        m_valid_d = 1'b0;
      end
    end
  end

  // NOTE: the accumulator and pipeline registers are reset along with the
  // control flops; a stale accumulator would leak into the first outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q       <= '0;
      v1_q      <= 1'b0;
      acc_q     <= '0;
      y_q       <= '0;
      m_valid_q <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      settled_q <= 1'b0;
`ifdef OPA_SAT_STATUS_EN
      sat_q     <= 1'b0;
      sticky_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      g_q       <= g_d;
      v1_q      <= v1_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      m_valid_q <= m_valid_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
`ifdef OPA_SAT_STATUS_EN
      sat_q     <= sat_d;
      sticky_q  <= sticky_d;
`endif
    end
  end

  assign y       = y_q;
  assign m_valid = m_valid_q;
  assign settled = settled_q;
`ifdef OPA_SAT_STATUS_EN
  assign sat        = sat_q;
  assign sat_sticky = sticky_q;
`endif

endmodule
